br_perf_monitor: RTL and testbench
==================================

BR_PERF_MONITOR -- requirements
Module: br_perf_monitor

Interface
REQ-001 Parameter CNT_W, default 32, width of every event counter.
REQ-002 Parameter HALT_INSN, default 32'h0000_006F (jal x0,0 self-loop), end-of-program fetch word.
REQ-003 Parameter HALT_REPEAT, default 4, consecutive HALT_INSN fetch cycles that declare program end.
REQ-004 Parameter DRAIN_CYC, default 3, cycles allowed after halt for in-flight branches to reach EX/MEM.
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 enable_i  in  1  level; starts counting when in IDLE.
REQ-008 clear_i  in  1  synchronous clear of all counters and state back to IDLE.
REQ-009 instr_i  in  32  word in the core's IF stage this cycle.
REQ-010 br_instr_i  in  1  control-transfer instruction resolved in EX/MEM this cycle.
REQ-011 br_misses_i  in  1  that resolution was a misprediction.
REQ-012 rpt_valid_o  out  1  report snapshot valid.
REQ-013 rpt_ready_i  in  1  consumer accepts report.
REQ-014 cycle_cnt_o, instr_cnt_o, br_cnt_o, miss_cnt_o  out  CNT_W each  snapshot counters.
REQ-015 done_o  out  1  report accepted, monitor finished.
REQ-016 ovf_o  out  1  sticky: some counter saturated.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, REPORT, DONE; reset state IDLE.
REQ-018 IDLE->RUN on enable_i=1; no counting in IDLE.
REQ-019 RUN: cycle_cnt +1 every cycle; instr_cnt +1 when instr_i is neither 32'h0000_0013 nor 32'h0; br_cnt +1 when br_instr_i; miss_cnt +1 when br_instr_i && br_misses_i.
REQ-020 br_misses_i with br_instr_i=0 is ignored, so miss_cnt <= br_cnt always.
REQ-021 Halt detector: run-length counter increments while instr_i==HALT_INSN, resets to 0 otherwise; RUN->DRAIN in the cycle it reaches HALT_REPEAT.
REQ-022 HALT_INSN fetches are counted in instr_cnt only until HALT_REPEAT is reached.
REQ-023 DRAIN: cycle_cnt and instr_cnt frozen; br_cnt/miss_cnt keep counting; DRAIN->REPORT after exactly DRAIN_CYC cycles.
REQ-024 REPORT: rpt_valid_o=1, all counter outputs stable until handshake; REPORT->DONE on the cycle rpt_valid_o && rpt_ready_i.
REQ-025 rpt_ready_i outside REPORT has no effect; rpt_valid_o never drops without handshake except on clear_i or reset.
REQ-026 DONE: done_o=1, counters held; exits only via clear_i or reset.
REQ-027 enable_i deasserting mid-RUN has no effect; only clear_i aborts.
REQ-028 Counters saturate at all-ones (no wrap); on the cycle any increment is suppressed by saturation, ovf_o sets and stays 1 until clear_i/reset.
REQ-029 clear_i has priority over every other event in the same cycle, including handshake and halt detection; next state IDLE, all outputs 0.
REQ-030 Counter outputs are registered live values in RUN/DRAIN and frozen values in REPORT/DONE; zero latency beyond one register.

Reset
REQ-031 rst_ni=0 asynchronously forces IDLE, all counters 0, halt run-length 0, rpt_valid_o=0, done_o=0, ovf_o=0, regardless of state including REPORT mid-handshake.
REQ-032 Operation resumes on the first rising edge after rst_ni deasserts.

Structure
REQ-033 FSM state enum, NOP encoding 32'h0000_0013 and default HALT_INSN constant live in shared package br_perf_pkg.
REQ-034 One sub-module sat_counter (CNT_W, inc, clr, outputs value and saturated flag), instantiated four times.
REQ-035 Block is instantiated beside the core in the bench top, fed by its miss/branch/fetch probes.

Verification
REQ-036 enable, 10 cycles of 32'h00A00093 then HALT_INSN x4 -> DRAIN; after 3 cycles rpt_valid_o=1, instr_cnt=13, cycle_cnt=14.
REQ-037 RUN with 8 br_instr pulses, 3 with br_misses_i, plus 2 br_misses_i alone -> br_cnt=8, miss_cnt=3.
REQ-038 HALT_INSN x3, one other word, HALT_INSN x4 -> halt only on the 4th of the second run.
REQ-039 REPORT with rpt_ready_i=0 for 5 cycles then 1 -> values stable 5 cycles, done_o=1 the next cycle.
REQ-040 CNT_W=4, 20 RUN cycles -> cycle_cnt=15, ovf_o=1 from the 16th counted cycle.
REQ-041 clear_i and rpt_ready_i together in REPORT -> IDLE, done_o=0; rst_ni low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/br_perf_pkg.sv
// rtl/br_perf_pkg.sv - shared types and constants for the branch performance monitor
package br_perf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // canonical RISC-V nop (addi x0,x0,0); never counted as a retired instruction
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // jal x0,0 self-loop used by test programs to signal end of execution
  localparam logic [31:0] DEFAULT_HALT_INSN = 32'h0000_006F;

endpackage

// File: rtl/br_perf_monitor_sat_counter.sv
// rtl/br_perf_monitor_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             saturated
);

  // at all-ones any further increment is dropped; the owner turns inc&saturated into overflow
  assign saturated = &value;

  // count up on inc, stick at all-ones, clear wins over inc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !saturated) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/br_perf_monitor.sv
// rtl/br_perf_monitor.sv - branch prediction performance monitor with halt detection and report handshake
module br_perf_monitor
  import br_perf_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter logic [31:0] HALT_INSN   = DEFAULT_HALT_INSN,
  parameter int          HALT_REPEAT = 4,
  parameter int          DRAIN_CYC   = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [31:0]      instr_i,
  input  logic             br_instr_i,
  input  logic             br_misses_i,
  output logic             rpt_valid_o,
  input  logic             rpt_ready_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic             done_o,
  output logic             ovf_o
);

  localparam int RUN_W = $clog2(HALT_REPEAT + 1);
  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HALT_REPEAT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [RUN_W-1:0] run_len;
  logic [DRN_W-1:0] drain_cnt;
  logic             is_halt;
  logic             halt_hit;
  logic             drain_end;
  logic             inc_cycle;
  logic             inc_instr;
  logic             inc_br;
  logic             inc_miss;
  logic [3:0]       inc_vec;
  logic [3:0]       sat_vec;

  assign is_halt   = (instr_i == HALT_INSN);
  // the fetch that completes the halt run ends RUN and is itself not an instruction
  assign halt_hit  = (state == ST_RUN) && is_halt && (run_len == RUN_LAST);
  assign drain_end = (state == ST_DRAIN) && (drain_cnt == DRN_LAST);

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and per-cycle counter enables; clear overrides everything
  always_comb begin
    state_nxt = state;
    inc_cycle = 1'b0;
    inc_instr = 1'b0;
    inc_br    = 1'b0;
    inc_miss  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_i) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        inc_cycle = 1'b1;
        inc_instr = (instr_i != NOP_INSN) && (instr_i != 32'h0) && !halt_hit;
        inc_br    = br_instr_i;
        inc_miss  = br_instr_i && br_misses_i;
        if (halt_hit) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        inc_br   = br_instr_i;
        inc_miss = br_instr_i && br_misses_i;
        if (drain_end) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        if (rpt_ready_i) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (clear_i) begin
      state_nxt = ST_IDLE;
      inc_cycle = 1'b0;
      inc_instr = 1'b0;
      inc_br    = 1'b0;
      inc_miss  = 1'b0;
    end
  end

  // consecutive HALT_INSN fetch run length, only tracked while running
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_len <= '0;
    end else if (clear_i || (state != ST_RUN) || halt_hit || !is_halt) begin
      run_len <= '0;
    end else begin
      run_len <= run_len + 1'b1;
    end
  end

  // drain window timer, lets branches already in flight at halt still be counted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_cnt <= '0;
    end else if (clear_i || (state != ST_DRAIN) || drain_end) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  assign inc_vec = {inc_miss, inc_br, inc_instr, inc_cycle};

  // sticky overflow: set whenever an increment is lost to saturation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_o <= 1'b0;
    end else if (clear_i) begin
      ovf_o <= 1'b0;
    end else if (|(inc_vec & sat_vec)) begin
      ovf_o <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .inc       (inc_cycle),
    .clr       (clear_i),
    .value     (cycle_cnt_o),
    .saturated (sat_vec[0])
  );

  sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .inc       (inc_instr),
    .clr       (clear_i),
    .value     (instr_cnt_o),
    .saturated (sat_vec[1])
  );

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .inc       (inc_br),
    .clr       (clear_i),
    .value     (br_cnt_o),
    .saturated (sat_vec[2])
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .inc       (inc_miss),
    .clr       (clear_i),
    .value     (miss_cnt_o),
    .saturated (sat_vec[3])
  );

  assign rpt_valid_o = (state == ST_REPORT);
  assign done_o      = (state == ST_DONE);

endmodule

// File: tb/tb_br_perf_monitor.sv
// tb/tb_br_perf_monitor.sv - scoreboard bench for br_perf_monitor
module tb_br_perf_monitor;
  import br_perf_pkg::*;

  localparam logic [31:0] HALT = 32'h0000_006F;
  localparam logic [31:0] ADDI = 32'h00A0_0093;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic        enable_b;
  logic        clear_b;
  logic [31:0] instr;
  logic        br;
  logic        miss;
  logic        rpt_ready;
  logic        rpt_valid;
  logic        done;
  logic        ovf;
  logic [31:0] cyc;
  logic [31:0] ins;
  logic [31:0] brc;
  logic [31:0] mis;
  logic        rpt_valid_b;
  logic        done_b;
  logic        ovf_b;
  logic [3:0]  cyc_b;
  logic [3:0]  ins_b;
  logic [3:0]  brc_b;
  logic [3:0]  mis_b;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [31:0] brc;
    logic [31:0] mis;
  } rpt_t;

  rpt_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  logic [11:0] br_tab   = 12'b1010_1101_1011;
  logic [11:0] miss_tab = 12'b0011_0001_0101;

  always #5 clk = ~clk;

  br_perf_monitor #(.CNT_W(32)) dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .clear_i     (clear),
    .instr_i     (instr),
    .br_instr_i  (br),
    .br_misses_i (miss),
    .rpt_valid_o (rpt_valid),
    .rpt_ready_i (rpt_ready),
    .cycle_cnt_o (cyc),
    .instr_cnt_o (ins),
    .br_cnt_o    (brc),
    .miss_cnt_o  (mis),
    .done_o      (done),
    .ovf_o       (ovf)
  );

  br_perf_monitor #(.CNT_W(4)) dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable_b),
    .clear_i     (clear_b),
    .instr_i     (instr),
    .br_instr_i  (br),
    .br_misses_i (miss),
    .rpt_valid_o (rpt_valid_b),
    .rpt_ready_i (rpt_ready),
    .cycle_cnt_o (cyc_b),
    .instr_cnt_o (ins_b),
    .br_cnt_o    (brc_b),
    .miss_cnt_o  (mis_b),
    .done_o      (done_b),
    .ovf_o       (ovf_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic rpt_t mk(input logic [31:0] c, input logic [31:0] i,
                              input logic [31:0] b, input logic [31:0] m);
    rpt_t r;
    r.cyc = c;
    r.ins = i;
    r.brc = b;
    r.mis = m;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] w, input logic b, input logic m);
    instr = w;
    br    = b;
    miss  = m;
    tick();
  endtask

  task automatic start_run();
    enable = 1'b1;
    step(NOP_INSN, 1'b0, 1'b0);
    enable = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(NOP_INSN, 1'b0, 1'b0);
    clear = 1'b0;
  endtask

  // report monitor: every accepted report is matched against the scoreboard head
  initial begin
    rpt_t e;
    forever begin
      @(negedge clk);
      if (rpt_valid && rpt_ready && !clear) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected report cycle=%0d instr=%0d br=%0d miss=%0d", cyc, ins, brc, mis);
        end else begin
          e = sb_q.pop_front();
          pops++;
          chk("rpt_cycle", cyc, e.cyc);
          chk("rpt_instr", ins, e.ins);
          chk("rpt_br",    brc, e.brc);
          chk("rpt_miss",  mis, e.mis);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; enable_b = 1'b0; clear_b = 1'b0;
    instr = NOP_INSN; br = 1'b0; miss = 1'b0; rpt_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", rpt_valid, 0);
    chk("rst_done",  done, 0);
    chk("rst_ovf",   ovf, 0);
    chk("rst_cycle", cyc, 0);
    chk("rst_instr", ins, 0);
    chk("rst_br",    brc, 0);
    chk("rst_miss",  mis, 0);
    rst_n = 1'b1;
    tick();

    // saturation on the 4-bit instance; nops so only the cycle counter overflows
    enable_b = 1'b1;
    step(NOP_INSN, 1'b0, 1'b0);
    enable_b = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(NOP_INSN, 1'b0, 1'b0);
      chk("sat_cycle", cyc_b, (k < 15) ? k : 15);
      chk("sat_ovf",   ovf_b, (k >= 16) ? 1 : 0);
    end
    chk("idle_nocount", cyc, 0);
    clear_b = 1'b1;
    step(NOP_INSN, 1'b0, 1'b0);
    clear_b = 1'b0;
    chk("sat_clr_ovf",   ovf_b, 0);
    chk("sat_clr_cycle", cyc_b, 0);

    // ten real instructions then the halt sequence
    start_run();
    repeat (10) step(ADDI, 1'b0, 1'b0);
    repeat (4) step(HALT, 1'b0, 1'b0);
    chk("t1_cycle", cyc, 14);
    chk("t1_instr", ins, 13);
    step(NOP_INSN, 1'b0, 1'b0);
    chk("t1_drain1_valid", rpt_valid, 0);
    step(NOP_INSN, 1'b0, 1'b0);
    chk("t1_drain2_valid", rpt_valid, 0);
    step(NOP_INSN, 1'b0, 1'b0);
    chk("t1_report_valid", rpt_valid, 1);
    sb_q.push_back(mk(14, 13, 0, 0));
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_valid_drop", rpt_valid, 0);
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    chk("t1_done_hold", done, 1);
    chk("t1_cycle_hold", cyc, 14);
    do_clear();
    chk("t1_clr_done",  done, 0);
    chk("t1_clr_cycle", cyc, 0);
    chk("t1_clr_instr", ins, 0);

    // branch / miss accounting, including misses flagged without a branch
    start_run();
    for (int i = 0; i < 12; i++) step(NOP_INSN, br_tab[i], miss_tab[i]);
    chk("t2_br",    brc, 8);
    chk("t2_miss",  mis, 3);
    chk("t2_instr", ins, 0);
    chk("t2_cycle", cyc, 12);
    repeat (4) step(HALT, 1'b0, 1'b0);
    sb_q.push_back(mk(16, 3, 8, 3));
    rpt_ready = 1'b1;
    n = 0;
    while (n < 10 && !done) begin
      step(NOP_INSN, 1'b0, 1'b0);
      n++;
    end
    rpt_ready = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_latency", n, 4);
    do_clear();

    // broken halt run, drain branch counting, held report
    start_run();
    repeat (3) step(HALT, 1'b0, 1'b0);
    step(NOP_INSN, 1'b0, 1'b0);
    repeat (3) step(HALT, 1'b0, 1'b0);
    chk("t3_cycle_run",  cyc, 7);
    chk("t3_instr_run",  ins, 6);
    step(HALT, 1'b0, 1'b0);
    chk("t3_cycle_halt", cyc, 8);
    chk("t3_instr_halt", ins, 6);
    step(HALT, 1'b1, 1'b1);
    chk("t3_cycle_frozen", cyc, 8);
    chk("t3_instr_frozen", ins, 6);
    chk("t3_br_drain",     brc, 1);
    step(NOP_INSN, 1'b1, 1'b0);
    step(NOP_INSN, 1'b0, 1'b0);
    chk("t3_valid",   rpt_valid, 1);
    chk("t3_br",      brc, 2);
    chk("t3_miss",    mis, 1);
    sb_q.push_back(mk(8, 6, 2, 1));
    for (int k = 0; k < 5; k++) begin
      step(ADDI, 1'b1, 1'b1);
      chk("t3_hold_valid", rpt_valid, 1);
      chk("t3_hold_cycle", cyc, 8);
      chk("t3_hold_br",    brc, 2);
    end
    rpt_ready = 1'b1;
    step(NOP_INSN, 1'b0, 1'b0);
    rpt_ready = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_ovf",  ovf, 0);
    do_clear();

    // clear and ready together in REPORT
    start_run();
    repeat (4) step(HALT, 1'b0, 1'b0);
    repeat (3) step(NOP_INSN, 1'b0, 1'b0);
    chk("t4_valid", rpt_valid, 1);
    clear = 1'b1;
    rpt_ready = 1'b1;
    step(NOP_INSN, 1'b0, 1'b0);
    clear = 1'b0;
    rpt_ready = 1'b0;
    chk("t4_valid_clr", rpt_valid, 0);
    chk("t4_done_clr",  done, 0);
    chk("t4_cycle_clr", cyc, 0);
    step(NOP_INSN, 1'b0, 1'b0);
    chk("t4_idle_done", done, 0);

    // asynchronous reset in the middle of RUN
    start_run();
    repeat (5) step(ADDI, 1'b1, 1'b1);
    chk("t5_cycle_pre", cyc, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cycle", cyc, 0);
    chk("t5_rst_instr", ins, 0);
    chk("t5_rst_br",    brc, 0);
    chk("t5_rst_miss",  mis, 0);
    chk("t5_rst_valid", rpt_valid, 0);
    chk("t5_rst_done",  done, 0);
    chk("t5_rst_ovf",   ovf, 0);
    tick();
    rst_n = 1'b1;
    step(ADDI, 1'b1, 1'b0);
    chk("t5_idle_after", cyc, 0);

    chk("sb_empty", sb_q.size(), 0);
    chk("reports",  pops, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
